// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
// Holds the FSM state encoding, requester identifiers, default bus widths,
// counter widths and the saturating-increment helper for the perf counters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  // Latency down-counter width; MEM_LAT is limited to 1..15 so it fits.
  localparam int CNT_W  = 4;
  localparam int XFER_W = 16;

  // Perf counters stick at all-ones instead of wrapping.
  function automatic logic [XFER_W-1:0] satInc(input logic [XFER_W-1:0] value);
    return (value == {XFER_W{1'b1}}) ? value : value + XFER_W'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_if.sv
// Bundle of every requester, memory and status signal around the arbiter.
// Ports of the bundle:
//   I side   : i_req, i_addr in; i_done, i_rdata out
//   D side   : d_req, d_wr, d_addr, d_wdata in; d_done, d_rdata out
//   memory   : mem_en, mem_wr, mem_addr, mem_wdata out; mem_rdata, mem_stall in
//   status   : busy, owner, i_xfer_cnt, d_xfer_cnt out
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_ctrl_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;

  logic              busy;
  logic              owner;
  logic [XFER_W-1:0] i_xfer_cnt;
  logic [XFER_W-1:0] d_xfer_cnt;

  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_stall,
    output i_done, i_rdata, d_done, d_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output busy, owner, i_xfer_cnt, d_xfer_cnt
  );

  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_stall,
    input  i_done, i_rdata, d_done, d_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  busy, owner, i_xfer_cnt, d_xfer_cnt
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports:
//   reqI, reqD  : pending requests from the I and D sides
//   lastOwner   : side granted most recently (OWNER_I / OWNER_D)
//   grantValid  : at least one request is pending
//   winner      : side to grant this cycle
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic reqI,
  input  logic reqD,
  input  logic lastOwner,
  output logic grantValid,
  output logic winner
);

  assign grantValid = reqI | reqD;

  // On a tie the side that did not win last time goes next.
  always_comb begin
    winner = OWNER_I;
    if (reqI && reqD) begin
      winner = ~lastOwner;
    end else if (reqD) begin
      winner = OWNER_D;
    end
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Shares the single main-memory port between the I-cache miss path and the
// D-cache miss/write-back path. One transaction is in flight at a time:
// grant in IDLE, hold the strobe in ISSUE until memory accepts, count down
// the fixed read latency in WAIT, then pulse the owner's done in DONE.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave view of mem_arbiter_ctrl_if (requesters, memory, status)
// Parameters:
//   MEM_LAT    : cycles from accepted issue to valid mem_rdata, 1..15
//   DATA_W     : data width
//   ADDR_W     : address width
module mem_arbiter_ctrl
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_arbiter_ctrl_if.slave   bus
);

  arbState_e         state;
  arbState_e         nextState;

  logic              grantValid;
  logic              winner;
  logic              ownerQ;

  logic [ADDR_W-1:0] latAddr;
  logic              latWr;
  logic [DATA_W-1:0] latWdata;
  logic [CNT_W-1:0]  cnt;

  logic [DATA_W-1:0] iRdataQ;
  logic [DATA_W-1:0] dRdataQ;
  logic [XFER_W-1:0] iXferCnt;
  logic [XFER_W-1:0] dXferCnt;

  logic              memEn;
  logic              iDone;
  logic              dDone;
  logic              busyOut;

  rr_pick2 picker (
    .reqI       (bus.i_req),
    .reqD       (bus.d_req),
    .lastOwner  (ownerQ),
    .grantValid (grantValid),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Requests are only looked at in IDLE; DONE always returns to IDLE so a
  // requester still high after its done is seen as a fresh request.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (grantValid)     nextState = ISSUE;
      ISSUE:   if (!bus.mem_stall) nextState = WAIT;
      WAIT:    if (cnt == '0)      nextState = DONE;
      DONE:                        nextState = IDLE;
      default:                     nextState = IDLE;
    endcase
  end

  always_comb begin
    memEn   = 1'b0;
    iDone   = 1'b0;
    dDone   = 1'b0;
    busyOut = (state != IDLE);
    unique case (state)
      ISSUE: memEn = 1'b1;
      DONE: begin
        iDone = (ownerQ == OWNER_I);
        dDone = (ownerQ == OWNER_D);
      end
      default: ;
    endcase
  end

  // Transaction capture, latency count, read-data return and perf counters.
  // The request is copied at grant so later requester changes are ignored.
  // The I side never writes, so its write flag and write data are zeroed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ownerQ   <= OWNER_I;
      latAddr  <= '0;
      latWr    <= 1'b0;
      latWdata <= '0;
      cnt      <= '0;
      iRdataQ  <= '0;
      dRdataQ  <= '0;
      iXferCnt <= '0;
      dXferCnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grantValid) begin
            ownerQ <= winner;
            if (winner == OWNER_D) begin
              latAddr  <= bus.d_addr;
              latWr    <= bus.d_wr;
              latWdata <= bus.d_wdata;
            end else begin
              latAddr  <= bus.i_addr;
              latWr    <= 1'b0;
              latWdata <= '0;
            end
          end
        end
        ISSUE: begin
          if (!bus.mem_stall) begin
            cnt <= CNT_W'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          // Read data is valid exactly in the cycle the count reaches zero.
          if (cnt == '0) begin
            if (!latWr) begin
              if (ownerQ == OWNER_I) begin
                iRdataQ <= bus.mem_rdata;
              end else begin
                dRdataQ <= bus.mem_rdata;
              end
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (ownerQ == OWNER_I) begin
            iXferCnt <= satInc(iXferCnt);
          end else begin
            dXferCnt <= satInc(dXferCnt);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_en     = memEn;
  assign bus.mem_wr     = memEn & latWr;
  assign bus.mem_addr   = latAddr;
  assign bus.mem_wdata  = latWdata;
  assign bus.i_done     = iDone;
  assign bus.d_done     = dDone;
  assign bus.i_rdata    = iRdataQ;
  assign bus.d_rdata    = dRdataQ;
  assign bus.busy       = busyOut;
  assign bus.owner      = ownerQ;
  assign bus.i_xfer_cnt = iXferCnt;
  assign bus.d_xfer_cnt = dXferCnt;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl: reset state, a table of single
// transactions, a round-robin tie sequence, counter saturation, reset in the
// middle of a transaction and a randomized run against a timestamp model.
// Each cycle the bench acts 1 time unit after the rising edge.
module tb_mem_arbiter_ctrl;
  import mem_arb_pkg::*;

  localparam int MEM_LAT = 4;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;

  typedef struct {
    string       name;
    logic        isD;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        preload;
    logic [15:0] memData;
    int          stalls;
    int          expDone;
    int          expEn;
    logic [15:0] expRdata;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Memory model state: backing store plus the one pending read return.
  logic [15:0] memArr [256];
  int          dueCycle = -100;
  logic [15:0] dueData  = '0;

  // Expected perf counters, kept as plain saturating integers.
  int expICnt = 0;
  int expDCnt = 0;

  mem_arbiter_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_arbiter_ctrl #(.MEM_LAT(MEM_LAT), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int satAdd(input int value);
    return (value < 65535) ? value + 1 : 65535;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Memory accepts an issue at the end of a cycle with mem_en=1, mem_stall=0;
  // read data appears for exactly cycle accept+MEM_LAT, junk otherwise.
  task automatic nextCycle();
    if (bus.mem_en === 1'b1 && bus.mem_stall === 1'b0) begin
      if (bus.mem_wr) begin
        memArr[bus.mem_addr[7:0]] = bus.mem_wdata;
      end else begin
        dueCycle = cyc + MEM_LAT;
        dueData  = memArr[bus.mem_addr[7:0]];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.mem_rdata = (cyc == dueCycle) ? dueData : 16'($urandom);
  endtask

  task automatic clearInputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_wr      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_stall = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    clearInputs();
    nextCycle();
    nextCycle();
    rst_n   = 1'b1;
    expICnt = 0;
    expDCnt = 0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " busy"},       bus.busy,       0);
    checkOutput({tag, " owner"},      bus.owner,      0);
    checkOutput({tag, " mem_en"},     bus.mem_en,     0);
    checkOutput({tag, " mem_wr"},     bus.mem_wr,     0);
    checkOutput({tag, " mem_addr"},   bus.mem_addr,   0);
    checkOutput({tag, " mem_wdata"},  bus.mem_wdata,  0);
    checkOutput({tag, " i_done"},     bus.i_done,     0);
    checkOutput({tag, " d_done"},     bus.d_done,     0);
    checkOutput({tag, " i_rdata"},    bus.i_rdata,    0);
    checkOutput({tag, " d_rdata"},    bus.d_rdata,    0);
    checkOutput({tag, " i_xfer_cnt"}, bus.i_xfer_cnt, 0);
    checkOutput({tag, " d_xfer_cnt"}, bus.d_xfer_cnt, 0);
  endtask

  // Runs one isolated transaction from IDLE; stalls the first v.stalls cycles
  // of mem_en, then reports when done pulsed and what the memory bus showed.
  task automatic applyStimulus(input vec_t v, output int doneAt, output int enCycles,
                               output logic [15:0] rdata, output logic busOk,
                               output logic otherDone);
    if (v.preload) memArr[v.addr[7:0]] = v.memData;
    if (v.isD) begin
      bus.d_req   = 1'b1;
      bus.d_wr    = v.wr;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
    end else begin
      bus.i_req   = 1'b1;
      bus.i_addr  = v.addr;
    end
    doneAt    = -1;
    enCycles  = 0;
    rdata     = '0;
    busOk     = 1'b1;
    otherDone = 1'b0;
    for (int k = 0; k < 40 && doneAt < 0; k++) begin
      if (k > 0) nextCycle();
      bus.mem_stall = bus.mem_en && (enCycles < v.stalls);
      if (bus.mem_en) begin
        enCycles++;
        if (bus.mem_addr !== v.addr || bus.mem_wr !== v.wr ||
            (v.wr && bus.mem_wdata !== v.wdata)) busOk = 1'b0;
      end
      if (v.isD ? bus.i_done : bus.d_done) otherDone = 1'b1;
      if (v.isD ? bus.d_done : bus.i_done) begin
        doneAt = k;
        rdata  = v.isD ? bus.d_rdata : bus.i_rdata;
      end
    end
    clearInputs();
    nextCycle();
    if (doneAt >= 0) begin
      if (v.isD) expDCnt = satAdd(expDCnt);
      else       expICnt = satAdd(expICnt);
    end
  endtask

  task automatic runTable();
    vec_t        vecs [7];
    int          doneAt;
    int          enCycles;
    logic [15:0] rdata;
    logic        busOk;
    logic        otherDone;
    vecs[0] = '{"iRead0040",        1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'hBEEF, 0, 6, 1, 16'hBEEF};
    vecs[1] = '{"dWrite1000",       1'b1, 1'b1, 16'h1000, 16'h1234, 1'b0, 16'h0000, 0, 6, 1, 16'h2222};
    vecs[2] = '{"dRead1000Stall3",  1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, 16'h0000, 3, 9, 4, 16'h1234};
    vecs[3] = '{"iRead00A5Stall1",  1'b0, 1'b0, 16'h00A5, 16'h0000, 1'b1, 16'h5A5A, 1, 7, 2, 16'h5A5A};
    vecs[4] = '{"dRead0041",        1'b1, 1'b0, 16'h0041, 16'h0000, 1'b1, 16'h0F0F, 0, 6, 1, 16'h0F0F};
    vecs[5] = '{"dWrite0040Stall2", 1'b1, 1'b1, 16'h0040, 16'hCAFE, 1'b0, 16'h0000, 2, 8, 3, 16'h0F0F};
    vecs[6] = '{"iRead0040Again",   1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 0, 6, 1, 16'hCAFE};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], doneAt, enCycles, rdata, busOk, otherDone);
      checkOutput({vecs[i].name, " done cycle"},   32'(doneAt),   32'(vecs[i].expDone));
      checkOutput({vecs[i].name, " mem_en cycles"}, 32'(enCycles), 32'(vecs[i].expEn));
      checkOutput({vecs[i].name, " rdata"},        rdata,         vecs[i].expRdata);
      checkOutput({vecs[i].name, " bus stable"},   busOk,         1);
      checkOutput({vecs[i].name, " other done"},   otherDone,     0);
      checkOutput({vecs[i].name, " owner"},        bus.owner,     vecs[i].isD);
      checkOutput({vecs[i].name, " busy after"},   bus.busy,      0);
      checkOutput({vecs[i].name, " i_xfer_cnt"},   bus.i_xfer_cnt, 32'(expICnt));
      checkOutput({vecs[i].name, " d_xfer_cnt"},   bus.d_xfer_cnt, 32'(expDCnt));
    end
  endtask

  // Both sides held high straight out of reset: D, then I, then D again,
  // each grant in the IDLE cycle right after the previous done.
  task automatic runTie();
    int          expCyc  [3] = '{6, 13, 20};
    logic        expSide [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] expData [3] = '{16'h2222, 16'h1111, 16'h2222};
    int          doneCyc [3];
    logic        doneSide[3];
    logic [15:0] doneData[3];
    int          nDone = 0;
    memArr[8'h10] = 16'h1111;
    memArr[8'h20] = 16'h2222;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0010;
    bus.d_req  = 1'b1;
    bus.d_wr   = 1'b0;
    bus.d_addr = 16'h0020;
    for (int k = 0; k < 60 && nDone < 3; k++) begin
      if (k > 0) nextCycle();
      if (k == 1) checkOutput("tie first owner", bus.owner, 1);
      if (k == 8) checkOutput("tie second owner", bus.owner, 0);
      if (bus.i_done || bus.d_done) begin
        doneCyc[nDone]  = k;
        doneSide[nDone] = bus.d_done;
        doneData[nDone] = bus.d_done ? bus.d_rdata : bus.i_rdata;
        nDone++;
      end
    end
    clearInputs();
    nextCycle();
    checkOutput("tie done count", 32'(nDone), 3);
    for (int i = 0; i < nDone; i++) begin
      checkOutput("tie done cycle", 32'(doneCyc[i]), 32'(expCyc[i]));
      checkOutput("tie done side",  doneSide[i],     expSide[i]);
      checkOutput("tie rdata",      doneData[i],     expData[i]);
    end
    expICnt = expICnt + 1;
    expDCnt = expDCnt + 2;
    checkOutput("tie i_xfer_cnt", bus.i_xfer_cnt, 32'(expICnt));
    checkOutput("tie d_xfer_cnt", bus.d_xfer_cnt, 32'(expDCnt));
  endtask

  task automatic runSaturation();
    vec_t        v;
    int          doneAt;
    int          enCycles;
    logic [15:0] rdata;
    logic        busOk;
    logic        otherDone;
    v = '{"satRead", 1'b1, 1'b0, 16'h0077, 16'h0000, 1'b1, 16'h7777, 0, 6, 1, 16'h7777};
    force dut.dXferCnt = 16'hFFFE;
    nextCycle();
    release dut.dXferCnt;
    expDCnt = 65534;
    checkOutput("sat preset", bus.d_xfer_cnt, 32'(expDCnt));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(v, doneAt, enCycles, rdata, busOk, otherDone);
      checkOutput("sat done cycle", 32'(doneAt), 6);
      checkOutput("sat d_xfer_cnt", bus.d_xfer_cnt, 32'(expDCnt));
    end
    checkOutput("sat final", bus.d_xfer_cnt, 16'hFFFF);
  endtask

  // Reset lands in the middle of WAIT: everything clears at once, no done.
  task automatic runResetMidWait();
    vec_t        v;
    int          doneAt;
    int          enCycles;
    logic [15:0] rdata;
    logic        busOk;
    logic        otherDone;
    int          stray = 0;
    memArr[8'h33] = 16'h3333;
    bus.i_req  = 1'b1;
    bus.i_addr = 16'h0033;
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("midwait busy before reset", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    checkResetState("midwait");
    clearInputs();
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      if (bus.i_done || bus.d_done || bus.busy) stray++;
    end
    checkOutput("midwait no activity in reset", 32'(stray), 0);
    rst_n   = 1'b1;
    expICnt = 0;
    expDCnt = 0;
    v = '{"postReset", 1'b0, 1'b0, 16'h0033, 16'h0000, 1'b0, 16'h0000, 0, 6, 1, 16'h3333};
    applyStimulus(v, doneAt, enCycles, rdata, busOk, otherDone);
    checkOutput("postReset done cycle", 32'(doneAt), 6);
    checkOutput("postReset rdata", rdata, 16'h3333);
    checkOutput("postReset i_xfer_cnt", bus.i_xfer_cnt, 1);
    checkOutput("postReset d_xfer_cnt", bus.d_xfer_cnt, 0);
  endtask

  // Random agents against a timestamp model: grant at cycle g, strobe from
  // g+1 until the first unstalled cycle a, done at a+MEM_LAT+1, next grant
  // no earlier than done+1. Owners scramble their inputs after grant.
  task automatic runRandom(input int nCycles);
    logic        iReq = 1'b0, dReq = 1'b0, dWr = 1'b0;
    logic [15:0] iAddr = '0, dAddr = '0, dWdata = '0;
    logic        txActive = 1'b0, accepted = 1'b0, txOwner = 1'b0, txWr = 1'b0;
    logic        lastOwner = 1'b0;
    int          grantCyc = 0, doneCyc = 0;
    logic [15:0] txAddr = '0, txWdata = '0, refData = '0;
    logic [15:0] expIRdata = '0, expDRdata = '0;
    logic        expEn, expBusy, expDoneNow, stall, ownerBusy;
    for (int n = 0; n < nCycles; n++) begin
      nextCycle();
      if (!iReq && $urandom_range(0, 2) == 0) begin
        iReq  = 1'b1;
        iAddr = 16'($urandom);
      end
      if (!dReq && $urandom_range(0, 2) == 0) begin
        dReq   = 1'b1;
        dWr    = 1'($urandom);
        dAddr  = 16'($urandom);
        dWdata = 16'($urandom);
      end
      stall      = ($urandom_range(0, 3) == 0);
      expEn      = txActive && (cyc > grantCyc) && !accepted;
      expBusy    = txActive && (cyc > grantCyc);
      expDoneNow = txActive && accepted && (cyc == doneCyc);
      ownerBusy  = txActive;
      bus.i_req     = iReq;
      bus.i_addr    = (ownerBusy && txOwner == OWNER_I) ? 16'($urandom) : iAddr;
      bus.d_req     = dReq;
      bus.d_wr      = (ownerBusy && txOwner == OWNER_D) ? 1'($urandom)  : dWr;
      bus.d_addr    = (ownerBusy && txOwner == OWNER_D) ? 16'($urandom) : dAddr;
      bus.d_wdata   = (ownerBusy && txOwner == OWNER_D) ? 16'($urandom) : dWdata;
      bus.mem_stall = stall;
      if (expDoneNow && !txWr) begin
        if (txOwner == OWNER_I) expIRdata = refData;
        else                    expDRdata = refData;
      end
      checkOutput("rand mem_en", bus.mem_en, expEn);
      checkOutput("rand busy",   bus.busy,   expBusy);
      checkOutput("rand owner",  bus.owner,  lastOwner);
      checkOutput("rand i_done", bus.i_done, expDoneNow && txOwner == OWNER_I);
      checkOutput("rand d_done", bus.d_done, expDoneNow && txOwner == OWNER_D);
      checkOutput("rand i_rdata", bus.i_rdata, expIRdata);
      checkOutput("rand d_rdata", bus.d_rdata, expDRdata);
      checkOutput("rand i_xfer_cnt", bus.i_xfer_cnt, 32'(expICnt));
      checkOutput("rand d_xfer_cnt", bus.d_xfer_cnt, 32'(expDCnt));
      if (expEn) begin
        checkOutput("rand mem_addr", bus.mem_addr, txAddr);
        checkOutput("rand mem_wr",   bus.mem_wr,   txWr);
        if (txWr) checkOutput("rand mem_wdata", bus.mem_wdata, txWdata);
      end
      if (!txActive) begin
        if (iReq || dReq) begin
          txOwner   = (iReq && dReq) ? !lastOwner : dReq;
          lastOwner = txOwner;
          txActive  = 1'b1;
          accepted  = 1'b0;
          grantCyc  = cyc;
          txAddr    = (txOwner == OWNER_D) ? dAddr  : iAddr;
          txWr      = (txOwner == OWNER_D) ? dWr    : 1'b0;
          txWdata   = (txOwner == OWNER_D) ? dWdata : 16'h0000;
        end
      end else if (expEn && !stall) begin
        accepted = 1'b1;
        doneCyc  = cyc + MEM_LAT + 1;
        refData  = memArr[txAddr[7:0]];
      end else if (expDoneNow) begin
        txActive = 1'b0;
        if (txOwner == OWNER_I) begin
          expICnt = satAdd(expICnt);
          iReq    = 1'b0;
        end else begin
          expDCnt = satAdd(expDCnt);
          dReq    = 1'b0;
        end
      end
    end
    clearInputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) memArr[i] = 16'($urandom);
    bus.mem_rdata = '0;
    doReset();
    checkResetState("reset");
    runTie();
    runTable();
    runSaturation();
    runResetMidWait();
    doReset();
    runRandom(800);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
